pmod_keypad_scanner: RTL and testbench

PMOD_KEYPAD_SCANNER -- requirements
Module: pmod_keypad_scanner

---
 rtl/keypad_pkg.sv | 21 ++
 rtl/pmod_keypad_scanner_if.sv | 20 ++
 rtl/keypad_debounce.sv | 54 +++++
 rtl/pmod_keypad_scanner.sv | 144 ++++++++++++++
 tb/tb_pmod_keypad_scanner.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: scan-state enum, event record and a width helper.
package keypad_pkg;

    typedef enum logic {
        DRIVE  = 1'b0,
        SAMPLE = 1'b1
    } scan_state_e;

    // Widest key index supported: 8 rows x 8 columns.
    localparam int MAX_KW = 6;

    typedef struct packed {
        logic [MAX_KW-1:0] code;
        logic              is_release;
    } key_event_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pmod_keypad_scanner_if.sv
// Key-event handshake between the scanner (master) and its consumer (slave).
interface pmod_keypad_scanner_if #(
    parameter int KW = 4
);
    logic          key_valid;
    logic          key_ready;
    logic [KW-1:0] key_code;
    logic          key_release;
    logic          overflow;

    modport master (
        output key_valid, key_code, key_release, overflow,
        input  key_ready
    );

    modport slave (
        input  key_valid, key_code, key_release, overflow,
        output key_ready
    );
endinterface

// File: rtl/keypad_debounce.sv
// Per-key debounce: counts consecutive samples that disagree with the debounced state.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic row_in,
    input  logic grant,
    output logic state,
    output logic toggle_req
);
    localparam int CW = clog2_min1(DEBOUNCE_SCANS + 1);

    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          state_q, state_d;

    assign cnt_inc    = cnt_q + CW'(1);
    assign toggle_req = sample_en && (row_in != state_q) && (cnt_inc == CW'(DEBOUNCE_SCANS));

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        cnt_d   = cnt_q;
        state_d = state_q;
        if (sample_en) begin
            if (row_in == state_q) begin
                cnt_d = '0;
            end else if (toggle_req) begin
                // A withheld toggle leaves both state and counter as they were.
                if (grant) begin
                    state_d = ~state_q;
                    cnt_d   = '0;
                end
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/pmod_keypad_scanner.sv
// Column-scanning keypad controller with debounce and a one-deep event register.
// Define KEYPAD_RELEASE_EVT_EN to report key releases as well as presses.
module pmod_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ROWS-1:0]        row,
    output logic [COLS-1:0]        col,
    pmod_keypad_scanner_if.master  kif
);
    localparam int NKEYS = ROWS * COLS;
    localparam int KW    = clog2_min1(NKEYS);
    localparam int DW    = clog2_min1(SETTLE_CYCLES);
    localparam int CIW   = clog2_min1(COLS);

    scan_state_e     state_q;
    logic [DW-1:0]   dwell_q;
    logic [CIW-1:0]  col_idx_q, col_idx_nxt;
    logic [COLS-1:0] col_q;
    logic            sampling;

    assign col_idx_nxt = (col_idx_q == CIW'(COLS - 1)) ? '0 : col_idx_q + CIW'(1);
    assign sampling    = (state_q == SAMPLE);

    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignment so every register sees pre-edge values.
        if (rst) begin
            state_q   <= DRIVE;
            dwell_q   <= '0;
            col_idx_q <= '0;
            col_q     <= ~COLS'(1);
        end else begin
            case (state_q)
                DRIVE: begin
                    if (dwell_q == DW'(SETTLE_CYCLES - 1)) begin
                        state_q <= SAMPLE;
                        dwell_q <= '0;
                    end else begin
                        dwell_q <= dwell_q + DW'(1);
                    end
                end
                SAMPLE: begin
                    state_q   <= DRIVE;
                    col_idx_q <= col_idx_nxt;
                    col_q     <= ~(COLS'(1) << col_idx_nxt);
                end
                default: state_q <= DRIVE;
            endcase
        end
    end

    assign col = col_q;

    logic [NKEYS-1:0] key_state, key_tog, evt_req, grant;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            keypad_debounce #(
                .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
            ) u_db (
                .clk        (clk),
                .rst        (rst),
                .sample_en  (sampling && (col_idx_q == CIW'(c))),
                .row_in     (row[r]),
                .grant      (grant[r*COLS + c]),
                .state      (key_state[r*COLS + c]),
                .toggle_req (key_tog[r*COLS + c])
            );
        end
    end

`ifdef KEYPAD_RELEASE_EVT_EN
    assign evt_req = key_tog;
`else
    // Releases toggle silently and never compete for the event slot.
    assign evt_req = key_tog & ~key_state;
`endif

    key_event_t win;
    logic       found;

    // Only one column is sampled at a time, so lowest flat index is lowest row.
    always_comb begin
        found = 1'b0;
        win   = '0;
        grant = '1;
        for (int k = 0; k < NKEYS; k++) begin
            if (evt_req[k]) begin
                if (!found) begin
                    found          = 1'b1;
                    win.code       = MAX_KW'(k);
                    win.is_release = key_state[k];
                end else begin
                    grant[k] = 1'b0;
                end
            end
        end
    end

    key_event_t evt_q, evt_d;
    logic       valid_q, valid_d;
    logic       ovf_q, ovf_d;

    always_comb begin
        evt_d   = evt_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (valid_q && kif.key_ready) begin
            valid_d = 1'b0;
        end
        if (found) begin
            if (!valid_q || kif.key_ready) begin
                valid_d = 1'b1;
                evt_d   = win;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            evt_q   <= evt_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign kif.key_valid   = valid_q;
    assign kif.key_code    = KW'(evt_q.code);
    assign kif.key_release = evt_q.is_release;
    assign kif.overflow    = ovf_q;

endmodule

// File: tb/tb_pmod_keypad_scanner.sv
// Directed bench for pmod_keypad_scanner with a 4x4 keypad model; honours KEYPAD_RELEASE_EVT_EN.
module tb_pmod_keypad_scanner;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int SCAN = 20;  // 4 columns x (4 settle + 1 sample)

`ifdef KEYPAD_RELEASE_EVT_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] keys;
        int          scans;
        int          exp_n;
        logic [3:0]  c0;
        logic        r0;
        logic [3:0]  c1;
        logic        r1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] keys = '0;

    pmod_keypad_scanner_if #(.KW(4)) kif ();

    pmod_keypad_scanner #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .SETTLE_CYCLES  (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .row (row),
        .col (col),
        .kif (kif)
    );

    always #5 clk = ~clk;

    // Key (r,c) closes row r onto column c; a low column drives the pressed row high.
    always_comb begin
        row = '0;
        for (int r = 0; r < ROWS; r++) begin
            row[r] = |(keys[r*COLS +: COLS] & ~col);
        end
    end

    int         n_vec  = 0;
    int         n_fail = 0;
    logic [4:0] evq[$];

    always @(negedge clk) begin
        if (!rst && kif.key_valid && kif.key_ready) begin
            evq.push_back({kif.key_release, kif.key_code});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        evq.delete();
    endtask

    vec_t       vecs[10];
    logic [3:0] exp_col;

    initial begin
        kif.key_ready = 1'b0;

        vecs[0] = '{16'h0000, 1, 0, 4'd0, 1'b0, 4'd0, 1'b0};
        vecs[1] = '{16'h0040, 2, 1, 4'd6, 1'b0, 4'd0, 1'b0};
        vecs[2] = '{16'h0000, 2, (REL_EN ? 1 : 0), 4'd6, 1'b1, 4'd0, 1'b0};
        vecs[3] = '{16'h0001, 1, 0, 4'd0, 1'b0, 4'd0, 1'b0};
        vecs[4] = '{16'h0000, 1, 0, 4'd0, 1'b0, 4'd0, 1'b0};
        vecs[5] = '{16'h0001, 1, 0, 4'd0, 1'b0, 4'd0, 1'b0};
        vecs[6] = '{16'h0001, 1, 1, 4'd0, 1'b0, 4'd0, 1'b0};
        vecs[7] = '{16'h0000, 2, (REL_EN ? 1 : 0), 4'd0, 1'b1, 4'd0, 1'b0};
        vecs[8] = '{16'h0202, 4, 2, 4'd1, 1'b0, 4'd9, 1'b0};
        vecs[9] = '{16'h0000, 4, (REL_EN ? 2 : 0), 4'd1, 1'b1, 4'd9, 1'b1};

        do_reset();
        check("rst_col", col, 4'b1110);
        check("rst_valid", kif.key_valid, 1'b0);
        check("rst_code", kif.key_code, 4'd0);
        check("rst_release", kif.key_release, 1'b0);
        check("rst_overflow", kif.overflow, 1'b0);

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((i / 5) % 4));
            check($sformatf("col_seq[%0d]", i), col, exp_col);
        end

        do_reset();
        kif.key_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            keys = vecs[i].keys;
            wait_cycles(vecs[i].scans * SCAN);
            check($sformatf("v%0d_count", i), evq.size(), vecs[i].exp_n);
            if (vecs[i].exp_n >= 1 && evq.size() >= 1) begin
                check($sformatf("v%0d_code0", i), evq[0][3:0], vecs[i].c0);
                check($sformatf("v%0d_rel0", i), evq[0][4], vecs[i].r0);
            end
            if (vecs[i].exp_n >= 2 && evq.size() >= 2) begin
                check($sformatf("v%0d_code1", i), evq[1][3:0], vecs[i].c1);
                check($sformatf("v%0d_rel1", i), evq[1][4], vecs[i].r1);
            end
            check($sformatf("v%0d_overflow", i), kif.overflow, 1'b0);
            evq.delete();
        end

        // Two presses with the consumer stalled: first held, second dropped.
        do_reset();
        kif.key_ready = 1'b0;
        keys = 16'h0041;
        wait_cycles(2 * SCAN);
        check("ovf_valid", kif.key_valid, 1'b1);
        check("ovf_code", kif.key_code, 4'd0);
        check("ovf_flag", kif.overflow, 1'b1);
        wait_cycles(SCAN);
        check("ovf_hold_valid", kif.key_valid, 1'b1);
        check("ovf_hold_code", kif.key_code, 4'd0);
        check("ovf_hold_release", kif.key_release, 1'b0);
        check("ovf_sticky", kif.overflow, 1'b1);
        kif.key_ready = 1'b1;
        wait_cycles(1);
        check("accept_clears_valid", kif.key_valid, 1'b0);
        check("accept_count", evq.size(), 1);
        evq.delete();
        wait_cycles(2 * SCAN);
        check("dropped_key_toggled", evq.size(), 0);
        check("ovf_still_set", kif.overflow, 1'b1);

        // Reset with an event pending and debounce progress in flight.
        do_reset();
        kif.key_ready = 1'b0;
        keys = 16'h0001;
        wait_cycles(2 * SCAN);
        check("pending_before_rst", kif.key_valid, 1'b1);
        do_reset();
        check("rst2_valid", kif.key_valid, 1'b0);
        check("rst2_code", kif.key_code, 4'd0);
        check("rst2_overflow", kif.overflow, 1'b0);
        kif.key_ready = 1'b1;
        wait_cycles(SCAN);
        check("rst2_no_early_event", evq.size(), 0);
        wait_cycles(SCAN);
        check("rst2_event_count", evq.size(), 1);
        if (evq.size() >= 1) begin
            check("rst2_event_code", evq[0][3:0], 4'd0);
            check("rst2_event_rel", evq[0][4], 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
